// File: rtl/rotor_step_controller.sv
// rotor_step_controller: three-rotor Enigma stepping sequencer with programmable notches
// and middle-rotor double-step; one step per accepted keypress.
module rotor_step_controller #(
    parameter int WIDTH       = 5,
    parameter int MODULUS     = 26,
    parameter int NOTCH_R_DEF = 21,
    parameter int NOTCH_M_DEF = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pos_l,
    input  logic [WIDTH-1:0] load_pos_m,
    input  logic [WIDTH-1:0] load_pos_r,
    input  logic [WIDTH-1:0] load_notch_m,
    input  logic [WIDTH-1:0] load_notch_r,
    output logic [WIDTH-1:0] pos_l,
    output logic [WIDTH-1:0] pos_m,
    output logic [WIDTH-1:0] pos_r,
    output logic             ready,
    output logic             step_done,
    output logic             load_err
);
    typedef enum logic [1:0] {IDLE, CHECK, STEP, DONE} state_t;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH:0]   MOD  = (WIDTH+1)'(MODULUS);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] notch_m, notch_r;
    logic             step_m, step_l;
    logic             load_ok, do_load, bad_load;

    function automatic logic [WIDTH-1:0] inc(input logic [WIDTH-1:0] x);
        return (x == LAST) ? '0 : x + ONE;
    endfunction

    function automatic logic in_range(input logic [WIDTH-1:0] x);
        return {1'b0, x} < MOD;
    endfunction

    always_comb begin
        load_ok   = in_range(load_pos_l) & in_range(load_pos_m) & in_range(load_pos_r)
                  & in_range(load_notch_m) & in_range(load_notch_r);
        do_load   = (state == IDLE) & load & load_ok;
        bad_load  = (state == IDLE) & load & ~load_ok;
        // LOAD has priority over a same-cycle key, which is dropped
        state_nxt = (state == IDLE)  ? ((key_valid & ~load) ? CHECK : IDLE) :
                    (state == CHECK) ? STEP :
                    (state == STEP)  ? DONE : IDLE;
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pos_l     <= '0;
            pos_m     <= '0;
            pos_r     <= '0;
            notch_m   <= WIDTH'(NOTCH_M_DEF);
            notch_r   <= WIDTH'(NOTCH_R_DEF);
            step_m    <= 1'b0;
            step_l    <= 1'b0;
            step_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_done <= (state == DONE);
            load_err  <= bad_load;
            if (do_load) begin
                pos_l   <= load_pos_l;
                pos_m   <= load_pos_m;
                pos_r   <= load_pos_r;
                notch_m <= load_notch_m;
                notch_r <= load_notch_r;
            end
            // middle on its own notch steps again and drags the left rotor (double step)
            if (state == CHECK) begin
                step_m <= (pos_r == notch_r) | (pos_m == notch_m);
                step_l <= (pos_m == notch_m);
            end
            if (state == STEP) begin
                pos_r <= inc(pos_r);
                pos_m <= step_m ? inc(pos_m) : pos_m;
                pos_l <= step_l ? inc(pos_l) : pos_l;
            end
        end
    end
endmodule

// File: tb/tb_rotor_step_controller.sv
// tb_rotor_step_controller: table-driven load/key vectors plus hand sequences for
// busy-period keys, LOAD/KEY collision and asynchronous reset in the middle of a step.
module tb_rotor_step_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_pos_l = '0, load_pos_m = '0, load_pos_r = '0;
    logic [4:0] load_notch_m = '0, load_notch_r = '0;
    logic [4:0] pos_l, pos_m, pos_r;
    logic       ready, step_done, load_err;
    int         total = 0;
    int         bad = 0;

    rotor_step_controller dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .load(load),
        .load_pos_l(load_pos_l), .load_pos_m(load_pos_m), .load_pos_r(load_pos_r),
        .load_notch_m(load_notch_m), .load_notch_r(load_notch_r),
        .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
        .ready(ready), .step_done(step_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_key;
        logic [4:0] l, m, r, nm, nr;
        logic [4:0] el, em, er;
        bit         err;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input bit k, input int l, m, r, nm, nr, el, em, er, input bit e);
        vec_t v;
        v.is_key = k;
        v.l = 5'(l); v.m = 5'(m); v.r = 5'(r); v.nm = 5'(nm); v.nr = 5'(nr);
        v.el = 5'(el); v.em = 5'(em); v.er = 5'(er);
        v.err = e;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pos(input string name, input int el, em, er);
        check({name, "_l"}, int'(pos_l), el);
        check({name, "_m"}, int'(pos_m), em);
        check({name, "_r"}, int'(pos_r), er);
    endtask

    // one key pulse; READY low for 3 cycles, STEP_DONE with new positions in the 4th
    task automatic press(input string name, input int el, em, er);
        @(negedge clk); key_valid = 1'b1;
        @(negedge clk); key_valid = 1'b0;
        check({name, "_ready_c1"}, int'(ready), 0);
        @(negedge clk);
        check({name, "_ready_c2"}, int'(ready), 0);
        @(negedge clk);
        check({name, "_ready_c3"}, int'(ready), 0);
        check({name, "_done_c3"}, int'(step_done), 0);
        @(negedge clk);
        check({name, "_ready_c4"}, int'(ready), 1);
        check({name, "_done_c4"}, int'(step_done), 1);
        check_pos(name, el, em, er);
    endtask

    task automatic do_load(input string name, input vec_t v, input bit kv);
        @(negedge clk);
        load = 1'b1; key_valid = kv;
        load_pos_l = v.l; load_pos_m = v.m; load_pos_r = v.r;
        load_notch_m = v.nm; load_notch_r = v.nr;
        @(negedge clk);
        load = 1'b0; key_valid = 1'b0;
        check({name, "_err"}, int'(load_err), int'(v.err));
        check({name, "_ready"}, int'(ready), 1);
        check_pos(name, v.el, v.em, v.er);
        @(negedge clk);
        check({name, "_err_clr"}, int'(load_err), 0);
        check({name, "_nodone"}, int'(step_done), 0);
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 3, 20, 4, 21,  0, 3, 20, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0,    0, 3, 21, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0,    0, 4, 22, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0,    1, 5, 23, 0);
        tbl[4]  = mk(0, 0, 0, 25, 4, 21,  0, 0, 25, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0,    0, 0, 0, 0);
        tbl[6]  = mk(0, 25, 4, 10, 4, 21, 25, 4, 10, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0,    0, 5, 11, 0);
        tbl[8]  = mk(0, 1, 26, 1, 1, 1,   0, 5, 11, 1);
        tbl[9]  = mk(0, 2, 2, 2, 2, 31,   0, 5, 11, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 0,    0, 5, 12, 0);
        tbl[11] = mk(0, 2, 7, 9, 7, 9,    2, 7, 9, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0,    3, 8, 10, 0);

        repeat (2) @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(step_done), 0);
        check("rst_err", int'(load_err), 0);
        check_pos("rst_pos", 0, 0, 0);
        rst_n = 1'b1;

        press("first_key", 0, 0, 1);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].is_key) press($sformatf("vec%0d_key", i), tbl[i].el, tbl[i].em, tbl[i].er);
            else do_load($sformatf("vec%0d_load", i), tbl[i], 1'b0);
        end

        // key held through CHECK/STEP/DONE into the next IDLE cycle: exactly one step
        @(negedge clk); key_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("held_done_early", int'(step_done), 0);
        @(negedge clk);
        key_valid = 1'b0;
        check("held_done", int'(step_done), 1);
        check_pos("held_pos", 3, 8, 11);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("held_quiet%0d", i), int'(step_done), 0);
        end
        check_pos("held_after", 3, 8, 11);

        // LOAD and KEY together: load applied, key dropped
        do_load("collide", mk(0, 6, 6, 6, 4, 21, 6, 6, 6, 0), 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("collide_ready%0d", i), int'(ready), 1);
            check($sformatf("collide_done%0d", i), int'(step_done), 0);
        end
        check_pos("collide_pos", 6, 6, 6);

        // LOAD while busy is ignored without LOAD_ERR
        @(negedge clk); key_valid = 1'b1;
        @(negedge clk); key_valid = 1'b0;
        load = 1'b1; load_pos_l = 5'd1; load_pos_m = 5'd27; load_pos_r = 5'd1;
        @(negedge clk);
        load = 1'b0;
        check("busy_load_err", int'(load_err), 0);
        repeat (2) @(negedge clk);
        check("busy_load_done", int'(step_done), 1);
        check_pos("busy_load_pos", 6, 6, 7);

        // asynchronous reset while in STEP
        @(negedge clk); key_valid = 1'b1;
        @(negedge clk); key_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_pos("midrst_pos", 0, 0, 0);
        check("midrst_ready", int'(ready), 1);
        check("midrst_done", int'(step_done), 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("midrst_done%0d", i), int'(step_done), 0);
        end
        check_pos("midrst_after", 0, 0, 0);

        press("post_rst_key", 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
